// File: rtl/ll_req_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ll_req_sequencer
//  Purpose  : Self-checking traffic sequencer for linked_list_top. Issues N
//             pushes then N pops (LIFO from head, FIFO from tail) over the
//             req/resp handshake, with an optional underflow probe pop, and
//             counts every response that disagrees with the expected result.
//  Revision : 1.0 - initial release
// ============================================================================
module ll_req_sequencer #(
    parameter int                 DATA_WD   = 8,
    parameter int                 PTR_WD    = 5,
    parameter int                 TYPE_WD   = 3,
    parameter logic [TYPE_WD-1:0] PUSH_CODE = TYPE_WD'(0),
    parameter logic [TYPE_WD-1:0] POPH_CODE = TYPE_WD'(1),
    parameter logic [TYPE_WD-1:0] POPT_CODE = TYPE_WD'(2),
    parameter int unsigned        TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_mode,
    input  logic [PTR_WD:0]    cfg_num,
    input  logic [DATA_WD-1:0] cfg_base,
    input  logic [DATA_WD-1:0] cfg_step,
    input  logic               cfg_chk_empty,
    output logic               req_vld,
    output logic [TYPE_WD-1:0] req_type,
    output logic [PTR_WD-1:0]  req_pos,
    output logic [DATA_WD-1:0] req_data,
    output logic               resp_taken,
    input  logic               resp_vld,
    input  logic [TYPE_WD-1:0] resp_type,
    input  logic [DATA_WD-1:0] resp_data,
    input  logic               resp_data_vld,
    input  logic               intf_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_cnt,
    output logic               timeout
);

    localparam logic [PTR_WD:0] c_max_items = (PTR_WD+1)'(2**PTR_WD);
    localparam logic [PTR_WD:0] c_one       = (PTR_WD+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_REL   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_PUSH  = 2'd0,
        PH_POP   = 2'd1,
        PH_PROBE = 2'd2
    } phase_t;

    state_t             r_state;
    phase_t             r_phase;
    logic               r_mode;
    logic               r_chk_empty;
    logic [PTR_WD:0]    r_num;
    logic [PTR_WD:0]    r_idx;
    logic [DATA_WD-1:0] r_base;
    logic [DATA_WD-1:0] r_step;
    // Running data value: next push data, then the expected data of the next pop.
    logic [DATA_WD-1:0] r_data;
    logic [31:0]        r_wait_cnt;
    logic [TYPE_WD-1:0] r_resp_type;
    logic [DATA_WD-1:0] r_resp_data;
    logic               r_resp_dvld;

    logic [PTR_WD:0]    w_num_clamped;
    logic               w_idx_last;
    logic [TYPE_WD-1:0] w_pop_code;
    logic               w_err_type;
    logic               w_err_data;
    logic [1:0]         w_err_inc;
    logic [8:0]         w_err_sum;
    logic [7:0]         w_err_next;
    logic               w_tmo_hit;

    assign req_pos       = '0;
    assign w_num_clamped = (cfg_num > c_max_items) ? c_max_items : cfg_num;
    assign w_idx_last    = ((r_idx + c_one) == r_num);
    assign w_pop_code    = r_mode ? POPT_CODE : POPH_CODE;

    // Per-response checks: echoed type, pop data, and the probe must come back empty.
    assign w_err_type = (r_resp_type != req_type);
    assign w_err_data = ((r_phase == PH_POP) && (!r_resp_dvld || (r_resp_data != r_data))) ||
                        ((r_phase == PH_PROBE) && r_resp_dvld);
    assign w_err_inc  = {1'b0, w_err_type} + {1'b0, w_err_data};
    assign w_err_sum  = {1'b0, err_cnt} + {7'd0, w_err_inc};
    assign w_err_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    assign w_tmo_hit  = (TIMEOUT != 0) && ((r_wait_cnt + 32'd1) == TIMEOUT);

    // Sequencer FSM; every output except req_pos is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= PH_PUSH;
            r_mode      <= 1'b0;
            r_chk_empty <= 1'b0;
            r_num       <= '0;
            r_idx       <= '0;
            r_base      <= '0;
            r_step      <= '0;
            r_data      <= '0;
            r_wait_cnt  <= '0;
            r_resp_type <= '0;
            r_resp_data <= '0;
            r_resp_dvld <= 1'b0;
            req_vld     <= 1'b0;
            req_type    <= '0;
            req_data    <= '0;
            resp_taken  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode      <= cfg_mode;
                        r_chk_empty <= cfg_chk_empty;
                        r_num       <= w_num_clamped;
                        r_base      <= cfg_base;
                        r_step      <= cfg_step;
                        r_data      <= cfg_base;
                        r_idx       <= '0;
                        err_cnt     <= '0;
                        timeout     <= 1'b0;
                        pass        <= 1'b0;
                        if (w_num_clamped != '0) begin
                            r_phase <= PH_PUSH;
                            r_state <= S_ISSUE;
                            busy    <= 1'b1;
                        end else if (cfg_chk_empty) begin
                            r_phase <= PH_PROBE;
                            r_state <= S_ISSUE;
                            busy    <= 1'b1;
                        end else begin
                            // Nothing to do: finish straight away with a clean result.
                            r_state <= S_FIN;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (intf_ready) begin
                        req_vld    <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                        if (r_phase == PH_PUSH) begin
                            req_type <= PUSH_CODE;
                            req_data <= r_data;
                        end else begin
                            req_type <= w_pop_code;
                            req_data <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (resp_vld) begin
                        req_vld     <= 1'b0;
                        r_resp_type <= resp_type;
                        r_resp_data <= resp_data;
                        r_resp_dvld <= resp_data_vld;
                        resp_taken  <= 1'b1;
                        r_state     <= S_ACK;
                    end else if (w_tmo_hit) begin
                        req_vld <= 1'b0;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                S_ACK: begin
                    resp_taken <= 1'b0;
                    err_cnt    <= w_err_next;
                    r_state    <= S_REL;
                end
                S_REL: begin
                    // A response held high is only counted once: wait for it to drop.
                    if (!resp_vld) begin
                        r_state <= S_ISSUE;
                        case (r_phase)
                            PH_PUSH: begin
                                if (w_idx_last) begin
                                    // LIFO: r_data already holds the last pushed value, popped first.
                                    r_phase <= PH_POP;
                                    r_idx   <= '0;
                                    if (r_mode) r_data <= r_base;
                                end else begin
                                    r_idx  <= r_idx + c_one;
                                    r_data <= r_data + r_step;
                                end
                            end
                            PH_POP: begin
                                if (w_idx_last) begin
                                    if (r_chk_empty) begin
                                        r_phase <= PH_PROBE;
                                    end else begin
                                        r_state <= S_FIN;
                                        busy    <= 1'b0;
                                        done    <= 1'b1;
                                        pass    <= (err_cnt == 8'd0) && !timeout;
                                    end
                                end else begin
                                    r_idx  <= r_idx + c_one;
                                    r_data <= r_mode ? (r_data + r_step) : (r_data - r_step);
                                end
                            end
                            default: begin
                                r_state <= S_FIN;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                pass    <= (err_cnt == 8'd0) && !timeout;
                            end
                        endcase
                    end
                end
                S_FIN: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ll_req_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ll_req_sequencer
//  Purpose  : Directed bench for ll_req_sequencer with a behavioural linked
//             list responder, request scoreboard and fault-injection knobs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ll_req_sequencer;

    localparam logic [2:0] PUSH_C = 3'd0;
    localparam logic [2:0] POPH_C = 3'd1;
    localparam logic [2:0] POPT_C = 3'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cfg_mode = 1'b0;
    logic [5:0] cfg_num = '0;
    logic [7:0] cfg_base = '0;
    logic [7:0] cfg_step = '0;
    logic       cfg_chk_empty = 1'b0;
    logic       req_vld;
    logic [2:0] req_type;
    logic [4:0] req_pos;
    logic [7:0] req_data;
    logic       resp_taken;
    logic       resp_vld;
    logic [2:0] resp_type;
    logic [7:0] resp_data;
    logic       resp_data_vld;
    logic       intf_ready = 1'b1;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic       timeout;

    ll_req_sequencer #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
        .cfg_num(cfg_num), .cfg_base(cfg_base), .cfg_step(cfg_step),
        .cfg_chk_empty(cfg_chk_empty), .req_vld(req_vld), .req_type(req_type),
        .req_pos(req_pos), .req_data(req_data), .resp_taken(resp_taken),
        .resp_vld(resp_vld), .resp_type(resp_type), .resp_data(resp_data),
        .resp_data_vld(resp_data_vld), .intf_ready(intf_ready), .busy(busy),
        .done(done), .pass(pass), .err_cnt(err_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Fault-injection knobs for the responder.
    int         corrupt_k   = -1;
    logic [7:0] corrupt_val = 8'h00;
    int         bad_type_k  = -1;
    bit         probe_bad   = 1'b0;
    bit         mute        = 1'b0;
    int         hold_len    = 1;

    // Behavioural list, transaction logs and expected request stream.
    logic [7:0] ll[$];
    logic [7:0] pushed_q[$];
    logic [7:0] popped_q[$];
    logic [2:0] exp_t_q[$];
    logic [7:0] exp_d_q[$];
    int req_idx = 0, pop_idx = 0, resp_served = 0, taken_cnt = 0;
    int exp_err = 0, exp_reqs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Responder: behaves as linked_list_top, answering each request on the next edge.
    initial begin : responder
        int rs, held;
        bit taken, dv;
        logic [2:0] t;
        logic [7:0] d;
        rs = 0; held = 0; taken = 1'b0;
        resp_vld = 1'b0; resp_type = '0; resp_data = '0; resp_data_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rs = 0;
                resp_vld = 1'b0; resp_type = '0; resp_data = '0; resp_data_vld = 1'b0;
            end else if (rs == 0) begin
                if (req_vld && !mute) begin
                    t = req_type; d = 8'h00; dv = 1'b0;
                    if (t == PUSH_C) begin
                        ll.push_front(req_data);
                        pushed_q.push_back(req_data);
                    end else begin
                        if (ll.size() > 0) begin
                            if (t == POPT_C) d = ll.pop_back();
                            else             d = ll.pop_front();
                            dv = 1'b1;
                            if (pop_idx == corrupt_k) d = corrupt_val;
                            popped_q.push_back(d);
                        end else begin
                            dv = probe_bad;
                        end
                        pop_idx++;
                    end
                    resp_type     = (req_idx == bad_type_k) ? (t ^ 3'd1) : t;
                    resp_data     = d;
                    resp_data_vld = dv;
                    resp_vld      = 1'b1;
                    req_idx++; resp_served++;
                    rs = 1; held = 1; taken = 1'b0;
                end
            end else begin
                if (resp_taken) taken = 1'b1;
                if (taken && held >= hold_len) begin
                    resp_vld = 1'b0;
                    rs = 0;
                end else begin
                    held++;
                end
            end
        end
    end

    // Compare process: each new request against the expected stream, and hold stability.
    initial begin : compare
        logic       prev;
        logic [2:0] ht;
        logic [7:0] hd;
        prev = 1'b0; ht = '0; hd = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (resp_taken) taken_cnt++;
                if (req_vld && !prev) begin
                    if (exp_t_q.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_req: got type %0d data 0x%0h, expected no request", req_type, req_data);
                    end else begin
                        chk("req_type", req_type, exp_t_q.pop_front());
                        chk("req_data", req_data, exp_d_q.pop_front());
                        chk("req_pos", req_pos, 0);
                    end
                    ht = req_type; hd = req_data;
                end else if (req_vld) begin
                    chk("req_hold", {req_type, req_data}, {ht, hd});
                end
                prev = req_vld;
            end
        end
    end

    task automatic start_run(input bit mode, input logic [5:0] num, input logic [7:0] base,
                             input logic [7:0] step, input bit ce);
        int ne;
        logic [2:0] pc;
        ne = (num > 6'd32) ? 32 : int'(num);
        pc = mode ? POPT_C : POPH_C;
        exp_t_q.delete(); exp_d_q.delete(); ll.delete(); pushed_q.delete(); popped_q.delete();
        req_idx = 0; pop_idx = 0; resp_served = 0; taken_cnt = 0;
        for (int i = 0; i < ne; i++) begin
            exp_t_q.push_back(PUSH_C);
            exp_d_q.push_back(8'(int'(base) + i * int'(step)));
        end
        for (int i = 0; i < ne + int'(ce); i++) begin
            exp_t_q.push_back(pc);
            exp_d_q.push_back(8'h00);
        end
        exp_reqs = 2 * ne + int'(ce);
        exp_err = 0;
        if (corrupt_k >= 0 && corrupt_k < ne) exp_err++;
        if (bad_type_k >= 0 && bad_type_k < exp_reqs) exp_err++;
        if (probe_bad && ce) exp_err++;
        @(negedge clk);
        cfg_mode = mode; cfg_num = num; cfg_base = base; cfg_step = step; cfg_chk_empty = ce;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble cfg: a latched run must not notice.
        cfg_mode = ~mode; cfg_num = 6'd7; cfg_base = ~base; cfg_step = step + 8'd3; cfg_chk_empty = ~ce;
        chk("busy_after_start", busy, (ne != 0 || ce));
    endtask

    task automatic finish_run(input bit exp_to, output int waited);
        waited = 0;
        while (!done && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL done_wait: got no done within %0d cycles, expected a done pulse", waited);
        end else begin
            chk("err_cnt", err_cnt, exp_err);
            chk("pass", pass, (exp_err == 0 && !exp_to));
            chk("timeout", timeout, exp_to);
            chk("busy_at_done", busy, 0);
            if (!exp_to) begin
                chk("reqs_left", exp_t_q.size(), 0);
                chk("resp_count", resp_served, exp_reqs);
                chk("taken_count", taken_cnt, resp_served);
            end
            @(negedge clk);
            chk("done_pulse_width", done, 0);
        end
        exp_t_q.delete(); exp_d_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int w, hi, dseen;
        logic [7:0] lit5 [5];
        logic [7:0] lit3 [3];

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_outputs", {req_vld, req_type, req_pos, req_data, resp_taken, busy, done, pass, err_cnt, timeout}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: LIFO, with a start pulse mid-run that must be ignored.
        start_run(1'b0, 6'd5, 8'h0A, 8'h01, 1'b0);
        repeat (6) @(negedge clk);
        cfg_num = 6'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run(1'b0, w);
        lit5 = '{8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
        chk("lifo_pop_count", popped_q.size(), 5);
        for (int k = 0; k < 5 && k < popped_q.size(); k++) chk("lifo_pop_data", popped_q[k], lit5[k]);
        chk("lifo_pass_lit", pass, 1);

        // 2: FIFO with 0x21 injected on the 2nd pop.
        corrupt_k = 1; corrupt_val = 8'h21;
        start_run(1'b1, 6'd3, 8'h10, 8'h10, 1'b0);
        finish_run(1'b0, w);
        chk("fifo_err_lit", err_cnt, 1);
        corrupt_k = -1;

        // 3: probe pop, clean then with data wrongly valid.
        start_run(1'b0, 6'd2, 8'h33, 8'h05, 1'b1);
        finish_run(1'b0, w);
        chk("probe_clean_pass", pass, 1);
        probe_bad = 1'b1;
        start_run(1'b1, 6'd2, 8'h33, 8'h05, 1'b1);
        finish_run(1'b0, w);
        chk("probe_bad_err", err_cnt, 1);
        probe_bad = 1'b0;

        // 4: long resp_vld, intf_ready held off, and a wrong echoed type.
        hold_len = 4;
        intf_ready = 1'b0;
        start_run(1'b0, 6'd1, 8'h5A, 8'h01, 1'b0);
        for (int c = 0; c < 10; c++) begin
            chk("req_vld_while_not_ready", req_vld, 0);
            @(negedge clk);
        end
        intf_ready = 1'b1;
        finish_run(1'b0, w);
        chk("hold_taken_lit", taken_cnt, 2);
        hold_len = 1;
        bad_type_k = 0;
        start_run(1'b0, 6'd3, 8'h40, 8'h02, 1'b0);
        finish_run(1'b0, w);
        bad_type_k = -1;

        // 5: responder silent -> timeout after 8 WAIT cycles.
        mute = 1'b1;
        start_run(1'b0, 6'd1, 8'h77, 8'h01, 1'b0);
        w = 0;
        while (!req_vld && w < 50) begin @(negedge clk); w++; end
        hi = 0;
        while (req_vld && hi < 50) begin @(negedge clk); hi++; end
        chk("timeout_wait_cycles", hi, 8);
        finish_run(1'b1, w);
        mute = 1'b0;
        start_run(1'b0, 6'd1, 8'h01, 8'h01, 1'b0);
        finish_run(1'b0, w);
        chk("timeout_cleared", timeout, 0);

        // 6: edge cases.
        start_run(1'b0, 6'd0, 8'h00, 8'h00, 1'b0);
        chk("n0_done_next_cycle", done, 1);
        finish_run(1'b0, w);
        start_run(1'b1, 6'd40, 8'h00, 8'h01, 1'b0);
        finish_run(1'b0, w);
        chk("clamp_push_count", pushed_q.size(), 32);
        start_run(1'b0, 6'd3, 8'hFE, 8'h01, 1'b0);
        finish_run(1'b0, w);
        lit3 = '{8'hFE, 8'hFF, 8'h00};
        chk("wrap_push_count", pushed_q.size(), 3);
        for (int k = 0; k < 3 && k < pushed_q.size(); k++) chk("wrap_push_data", pushed_q[k], lit3[k]);

        // Reset in the middle of a run: outputs clear, no done afterwards.
        start_run(1'b0, 6'd5, 8'h20, 8'h01, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun_reset_outputs", {req_vld, req_type, req_pos, req_data, resp_taken, busy, done, pass, err_cnt, timeout}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_t_q.delete(); exp_d_q.delete();
        dseen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) dseen++;
        end
        chk("no_done_after_abort", dseen, 0);
        start_run(1'b1, 6'd2, 8'h90, 8'h01, 1'b0);
        finish_run(1'b0, w);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
